// File: rtl/fir_tdm_mac.sv
// Time-multiplexed single-multiplier FIR serving CH channels with shared, runtime-writable coefficients.
// Optional FIR_SAT_EN: saturate (instead of wrap) when the output is narrower than the accumulator.
module fir_tdm_mac #(
    parameter int unsigned IW   = 12,
    parameter int unsigned CW   = 12,
    parameter int unsigned TAPS = 8,
    parameter int unsigned CH   = 1,
    parameter int unsigned OW   = 31,
    localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1,
    localparam int unsigned TW  = $clog2(TAPS),
    localparam int unsigned AW  = IW + CW + TW
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ce,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [IW-1:0]        i_sample,
    input  logic [CHW-1:0]       i_ch,
    input  logic                 i_coef_we,
    input  logic [TW-1:0]        i_coef_addr,
    input  logic [CW-1:0]        i_coef_data,
    output logic [OW-1:0]        o_result,
    output logic [CHW-1:0]       o_ch,
    output logic                 o_data_valid,
    output logic                 o_sat
);

    localparam int unsigned PW = IW + CW;

    typedef enum logic {IDLE, MAC} state_t;

    state_t state, state_nxt;

    logic signed [IW-1:0] hist [CH][TAPS];
    logic [TW-1:0]        wr_ptr [CH];
    logic signed [CW-1:0] coef [TAPS];
    logic signed [AW-1:0] acc;
    logic [TW-1:0]        k;
    logic [TW-1:0]        base;
    logic [CHW-1:0]       ch_q;

    logic                 ch_ok_c, addr_ok_c;
    logic                 accept_c, coef_wr_c, last_c;
    logic [TW-1:0]        rd_idx_c;
    logic signed [IW-1:0] x_c;
    logic signed [CW-1:0] coef_c;
    logic signed [PW-1:0] prod_c;
    logic signed [AW-1:0] acc_sum_c;
    logic [OW-1:0]        res_c;
    logic                 sat_c;

    // Range checks widened by one bit so CH / TAPS equal to a power of two stay representable
    assign ch_ok_c   = {1'b0, i_ch} < (CHW+1)'(CH);
    assign addr_ok_c = {1'b0, i_coef_addr} < (TW+1)'(TAPS);

    // Next-state and control strobes
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        coef_wr_c = 1'b0;
        last_c    = 1'b0;
        case (state)
            IDLE: begin
                coef_wr_c = i_coef_we && addr_ok_c;
                if (i_valid && ch_ok_c) begin
                    accept_c  = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                if (k == TW'(TAPS - 1)) begin
                    last_c    = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // State register; o_ready mirrors the idle state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            o_ready <= 1'b1;
        end else if (i_ce) begin
            state   <= state_nxt;
            o_ready <= (state_nxt == IDLE);
        end
    end

    // Circular history index of tap k, modulo TAPS for any TAPS
    always_comb begin
        if (base >= k) rd_idx_c = base - k;
        else           rd_idx_c = base + TW'(TAPS) - k;
    end

    assign x_c       = hist[ch_q][rd_idx_c];
    assign coef_c    = coef[k];
    assign prod_c    = PW'(x_c) * PW'(coef_c);
    assign acc_sum_c = acc + {{TW{prod_c[PW-1]}}, prod_c};

    // Accumulator to output width conversion
    generate
        if (OW >= AW) begin : g_ext
            assign res_c = OW'(acc_sum_c);
            assign sat_c = 1'b0;
        end else begin : g_narrow
            logic unused_hi_c;
`ifdef FIR_SAT_EN
            localparam logic signed [AW-1:0] RMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
            localparam logic signed [AW-1:0] RMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
            logic hi_c, lo_c;
            assign hi_c  = acc_sum_c > RMAX;
            assign lo_c  = acc_sum_c < RMIN;
            assign res_c = hi_c ? {1'b0, {(OW-1){1'b1}}} :
                           lo_c ? {1'b1, {(OW-1){1'b0}}} : acc_sum_c[OW-1:0];
            assign sat_c = hi_c | lo_c;
            assign unused_hi_c = 1'b0;
`else
            assign res_c = acc_sum_c[OW-1:0];
            assign sat_c = 1'b0;
            assign unused_hi_c = ^acc_sum_c[AW-1:OW];
`endif
        end
    endgenerate

    // Datapath: history, coefficients, accumulator and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned c = 0; c < CH; c++) begin
                wr_ptr[c] <= '0;
                for (int unsigned t = 0; t < TAPS; t++) hist[c][t] <= '0;
            end
            for (int unsigned t = 0; t < TAPS; t++) coef[t] <= '0;
            acc          <= '0;
            k            <= '0;
            base         <= '0;
            ch_q         <= '0;
            o_result     <= '0;
            o_ch         <= '0;
            o_data_valid <= 1'b0;
            o_sat        <= 1'b0;
        end else if (i_ce) begin
            o_data_valid <= 1'b0;
            o_sat        <= 1'b0;
            if (coef_wr_c) coef[i_coef_addr] <= i_coef_data;
            if (accept_c) begin
                hist[i_ch][wr_ptr[i_ch]] <= i_sample;
                wr_ptr[i_ch] <= (wr_ptr[i_ch] == TW'(TAPS - 1)) ? '0 : wr_ptr[i_ch] + TW'(1);
                base <= wr_ptr[i_ch];
                ch_q <= i_ch;
                acc  <= '0;
                k    <= '0;
            end else if (state == MAC) begin
                acc <= acc_sum_c;
                k   <= k + TW'(1);
                if (last_c) begin
                    o_result     <= res_c;
                    o_ch         <= ch_q;
                    o_data_valid <= 1'b1;
                    o_sat        <= sat_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_tdm_mac.sv
// Self-checking bench for fir_tdm_mac: a behavioural FIR model feeds a per-instance expected-result queue.
module tb_fir_tdm_mac;

    logic clk, rst, ce;
    bit   stall_en;

    // Instance A: 3 channels, 8 taps, full-width output
    logic        a_valid, a_ready, a_we, a_dv, a_sat;
    logic [11:0] a_sample, a_cdata;
    logic [1:0]  a_ch, a_och;
    logic [2:0]  a_addr;
    logic [30:0] a_res;

    // Instance B: 1 channel, 5 taps, 16-bit output (narrower than the accumulator)
    logic        b_valid, b_ready, b_we, b_dv, b_sat;
    logic [11:0] b_sample, b_cdata;
    logic [0:0]  b_ch, b_och;
    logic [2:0]  b_addr;
    logic [15:0] b_res;

    fir_tdm_mac #(.IW(12), .CW(12), .TAPS(8), .CH(3), .OW(31)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(a_valid), .o_ready(a_ready),
        .i_sample(a_sample), .i_ch(a_ch), .i_coef_we(a_we), .i_coef_addr(a_addr),
        .i_coef_data(a_cdata), .o_result(a_res), .o_ch(a_och), .o_data_valid(a_dv), .o_sat(a_sat));

    fir_tdm_mac #(.IW(12), .CW(12), .TAPS(5), .CH(1), .OW(16)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(b_valid), .o_ready(b_ready),
        .i_sample(b_sample), .i_ch(b_ch), .i_coef_we(b_we), .i_coef_addr(b_addr),
        .i_coef_data(b_cdata), .o_result(b_res), .o_ch(b_och), .o_data_valid(b_dv), .o_sat(b_sat));

    typedef struct {
        longint res;
        int     ch;
        int     sat;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   hist_a[3][8];
    int   ptr_a[3];
    int   coef_a[8];
    int   hist_b[5];
    int   ptr_b;
    int   coef_b[5];
    int   n_checks, n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Reference conversion of a full-precision sum to ow output bits
    function automatic exp_t conv(input longint v, input int ow, input int ch);
        exp_t   e;
        longint hi, lo;
        hi    = (longint'(1) <<< (ow - 1)) - 1;
        lo    = -hi - 1;
        e.ch  = ch;
        e.sat = 0;
        e.res = v;
        if (v > hi || v < lo) begin
`ifdef FIR_SAT_EN
            e.res = (v > hi) ? hi : lo;
            e.sat = 1;
`else
            e.res = v & ((longint'(1) <<< ow) - 1);
            if (e.res > hi) e.res = e.res - (longint'(1) <<< ow);
`endif
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            ptr_a[c] = 0;
            for (int t = 0; t < 8; t++) hist_a[c][t] = 0;
        end
        for (int t = 0; t < 8; t++) coef_a[t] = 0;
        for (int t = 0; t < 5; t++) begin hist_b[t] = 0; coef_b[t] = 0; end
        ptr_b = 0;
    endtask

    task automatic model_a(input int ch, input int s);
        longint acc;
        int     p;
        acc = 0;
        p   = ptr_a[ch];
        hist_a[ch][p] = s;
        ptr_a[ch] = (p + 1) % 8;
        for (int t = 0; t < 8; t++) acc += longint'(coef_a[t]) * longint'(hist_a[ch][(p - t + 8) % 8]);
        q_a.push_back(conv(acc, 31, ch));
    endtask

    task automatic model_b(input int s);
        longint acc;
        int     p;
        acc = 0;
        p   = ptr_b;
        hist_b[p] = s;
        ptr_b = (p + 1) % 5;
        for (int t = 0; t < 5; t++) acc += longint'(coef_b[t]) * longint'(hist_b[(p - t + 5) % 5]);
        q_b.push_back(conv(acc, 16, 0));
    endtask

    // Offer one sample (optionally with a coefficient write) to A and model it at the accepting edge
    task automatic send_a(input int ch, input int s, input bit wr, input int addr, input int cd);
        int n;
        n = 0;
        while (!a_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!a_ready) begin check("a_ready_timeout", 0, 1); return; end
        a_valid = 1'b1; a_ch = 2'(ch); a_sample = 12'(s);
        a_we = wr; a_addr = 3'(addr); a_cdata = 12'(cd);
        n = 0;
        do begin @(posedge clk); n++; end while (!ce && n < 200);
        if (wr) coef_a[addr] = cd;
        if (ch < 3) model_a(ch, s);
        #1;
        a_valid = 1'b0; a_we = 1'b0;
    endtask

    task automatic coef_a_wr(input int addr, input int cd);
        int n;
        n = 0;
        while (!a_ready && n < 200) begin @(posedge clk); #1; n++; end
        a_we = 1'b1; a_addr = 3'(addr); a_cdata = 12'(cd);
        @(posedge clk);
        coef_a[addr] = cd;
        #1;
        a_we = 1'b0;
    endtask

    task automatic send_b(input int ch, input int s);
        int n;
        n = 0;
        while (!b_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!b_ready) begin check("b_ready_timeout", 0, 1); return; end
        b_valid = 1'b1; b_ch = 1'(ch); b_sample = 12'(s);
        @(posedge clk);
        if (ch < 1) model_b(s);
        #1;
        b_valid = 1'b0;
    endtask

    task automatic coef_b_wr(input int addr, input int cd);
        b_we = 1'b1; b_addr = 3'(addr); b_cdata = 12'(cd);
        @(posedge clk);
        if (addr < 5) coef_b[addr] = cd;
        #1;
        b_we = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_a.size() + q_b.size()) != 0 && n < 2000) begin @(posedge clk); n++; end
        repeat (12) @(posedge clk);
        #1;
        check("drain_pending", longint'(q_a.size() + q_b.size()), 0);
    endtask

    // Clock-enable driver: random during the stall phase, otherwise held high
    initial begin
        ce = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ce = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: a pulse is consumed on the edge where ce is high
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ce) begin
            if (a_dv) begin
                if (q_a.size() == 0) check("a_unexpected_output", 1, 0);
                else begin
                    e = q_a.pop_front();
                    check("a_result", longint'($signed(a_res)), e.res);
                    check("a_ch", longint'(a_och), longint'(e.ch));
                    check("a_sat", longint'(a_sat), longint'(e.sat));
                end
            end
            if (b_dv) begin
                if (q_b.size() == 0) check("b_unexpected_output", 1, 0);
                else begin
                    e = q_b.pop_front();
                    check("b_result", longint'($signed(b_res)), e.res);
                    check("b_ch", longint'(b_och), longint'(e.ch));
                    check("b_sat", longint'(b_sat), longint'(e.sat));
                end
            end
        end
    end

    initial begin
        int n;
        int sv[6];
        n_checks = 0; n_fail = 0; stall_en = 1'b0;
        a_valid = 0; a_we = 0; a_sample = '0; a_ch = '0; a_addr = '0; a_cdata = '0;
        b_valid = 0; b_we = 0; b_sample = '0; b_ch = '0; b_addr = '0; b_cdata = '0;
        model_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_a_ready", longint'(a_ready), 1);
        check("rst_a_result", longint'(a_res), 0);
        check("rst_a_ch", longint'(a_och), 0);
        check("rst_a_valid", longint'(a_dv), 0);
        check("rst_a_sat", longint'(a_sat), 0);
        check("rst_b_ready", longint'(b_ready), 1);

        // Impulse response with coefficients 1..8, plus latency of the first result
        for (int t = 0; t < 8; t++) coef_a_wr(t, t + 1);
        send_a(0, 1, 0, 0, 0);
        check("busy_after_accept", longint'(a_ready), 0);
        n = 0;
        while (!a_dv && n < 50) begin @(posedge clk); #1; n++; end
        check("latency_edges", longint'(n), 8);
        check("ready_after_result", longint'(a_ready), 1);
        for (int i = 0; i < 7; i++) send_a(0, 0, 0, 0, 0);
        drain();

        // Channel isolation: ch0 impulse interleaved with ch2 constant 2, coefficients all 1
        for (int t = 0; t < 8; t++) coef_a_wr(t, 1);
        for (int i = 0; i < 9; i++) begin
            send_a(0, (i == 0) ? 1 : 0, 0, 0, 0);
            send_a(2, 2, 0, 0, 0);
        end
        drain();

        // Out-of-range channel: handshake completes, nothing else happens
        send_a(3, 1234, 0, 0, 0);
        check("bad_ch_ready", longint'(a_ready), 1);
        send_a(0, 0, 0, 0, 0);
        drain();

        // Coefficient writes: ignored while busy, applied on the accept edge
        begin
            int cset[8];
            cset = '{3, -2, 5, 7, -1, 4, 2, -6};
            for (int t = 0; t < 8; t++) coef_a_wr(t, cset[t]);
        end
        send_a(1, 10, 0, 0, 0);
        @(posedge clk); #1;
        a_we = 1'b1; a_addr = 3'd0; a_cdata = 12'd999;
        @(posedge clk); #1;
        a_we = 1'b0;
        send_a(1, 5, 0, 0, 0);
        send_a(1, 7, 1, 1, 11);
        send_a(1, -3, 0, 0, 0);
        drain();

        // Random clock-enable stalls during MAC
        stall_en = 1'b1;
        for (int i = 0; i < 6; i++) sv[i] = int'($urandom_range(0, 4094)) - 2047;
        for (int i = 0; i < 6; i++) send_a(i % 3, sv[i], 0, 0, 0);
        drain();
        stall_en = 1'b0;
        @(posedge clk); #1;

        // Overflow on the narrow instance, with dropped out-of-range coefficient writes
        for (int t = 0; t < 5; t++) coef_b_wr(t, 2047);
        coef_b_wr(5, 1000);
        coef_b_wr(7, -1000);
        for (int i = 0; i < 5; i++) send_b(0, 2047);
        send_b(1, 2047);
        check("b_bad_ch_ready", longint'(b_ready), 1);
        send_b(0, -2048);
        drain();

        // Reset in the middle of a computation
        for (int t = 0; t < 8; t++) coef_a_wr(t, t + 1);
        send_a(0, 1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_ready", longint'(a_ready), 1);
        check("midrst_valid", longint'(a_dv), 0);
        check("midrst_result", longint'(a_res), 0);
        q_a.delete();
        q_b.delete();
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        send_a(0, 1, 0, 0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
